// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg
//   Shared definitions for the EX/MEM pipeline register and its data-bus
//   sequencer: register-file bus types, load/store op codes, RV32I funct3
//   width codes, FSM state encodings and small decode helpers.
//   The optional EX_MEM_MISALIGN_EXC_EN build uses is_misaligned().
package ex_mem_pkg;

    // Register-file address and data buses (RegAddrBus / RegBus).
    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] reg_bus_t;

    // Load/store operation carried down from EX. The reserved code
    // behaves exactly like LS_NONE.
    typedef enum logic [1:0] {
        LS_NONE  = 2'b00,
        LS_LOAD  = 2'b01,
        LS_STORE = 2'b10,
        LS_RSVD  = 2'b11
    } ls_op_e;

    // RV32I funct3 width/sign codes for loads and stores.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Bus sequencer states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    // funct3[1:0] carries the access width; funct3[2] is the unsigned flag.
    // Unused width codes fall back to a full word.
    function automatic size_e f3_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [1:0] ls_op);
        return (ls_op == LS_LOAD) || (ls_op == LS_STORE);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        case (f3_size(funct3))
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_mem_if.sv
// ex_mem_if
//   Data-bus interface between the EX/MEM sequencer (master) and the
//   memory / bus slave.
//   dbus_req   master->slave  request, held until ack
//   dbus_wr    master->slave  1 = store
//   dbus_addr  master->slave  word-aligned address
//   dbus_wdata master->slave  lane-replicated store data
//   dbus_sel   master->slave  byte enables
//   dbus_ack   slave->master  transaction complete, rdata valid same cycle
//   dbus_rdata slave->master  read data
interface ex_mem_if #(
    parameter int AW = 32
) ();
    logic          dbus_req;
    logic          dbus_wr;
    logic [AW-1:0] dbus_addr;
    logic [31:0]   dbus_wdata;
    logic [3:0]    dbus_sel;
    logic          dbus_ack;
    logic [31:0]   dbus_rdata;

    modport master (
        output dbus_req, dbus_wr, dbus_addr, dbus_wdata, dbus_sel,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_wr, dbus_addr, dbus_wdata, dbus_sel,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/ex_mem_ls_align.sv
// ex_mem_ls_align
//   Combinational load/store alignment.
//   funct3    in   access width / sign
//   addr_lo   in   effective address bits [1:0]
//   sdata     in   store data (rs2)
//   rdata     in   raw bus read data
//   sel       out  byte enables
//   wdata     out  store data replicated across lanes
//   rdata_ext out  selected byte/half, sign- or zero-extended
//   Without EX_MEM_MISALIGN_EXC_EN the address low bits are forced to the
//   natural alignment of the access; with it, misaligned accesses never
//   reach the bus, so the raw offset is used.
module ex_mem_ls_align
    import ex_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] rdata_ext
);

    size_e       size;
    logic [1:0]  lo;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sign_ext;

    assign size     = f3_size(funct3);
    assign sign_ext = ~funct3[2];

    always_comb begin
`ifndef EX_MEM_MISALIGN_EXC_EN
        case (size)
            SZ_HALF: lo = {addr_lo[1], 1'b0};
            SZ_WORD: lo = 2'b00;
            default: lo = addr_lo;
        endcase
`else
        lo = addr_lo;
`endif
    end

    always_comb begin
        case (size)
            SZ_BYTE: sel = 4'b0001 << lo;
            SZ_HALF: sel = 4'b0011 << lo;
            default: sel = 4'b1111;
        endcase
    end

    // Each byte lane takes the byte of sdata it would hold if the access
    // were repeated to fill the word: byte -> lane 0 everywhere,
    // half -> lanes 0/1 alternating, word -> unchanged.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata[8*gi +: 8] = (size == SZ_BYTE) ? sdata[7:0] :
                                  (size == SZ_HALF) ? sdata[8*(gi%2) +: 8] :
                                                      sdata[8*gi +: 8];
    end

    assign byte_v = rdata[{lo, 3'b000} +: 8];
    assign half_v = rdata[{lo[1], 4'b0000} +: 16];

    always_comb begin
        case (size)
            SZ_BYTE: rdata_ext = {{24{sign_ext & byte_v[7]}}, byte_v};
            SZ_HALF: rdata_ext = {{16{sign_ext & half_v[15]}}, half_v};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/ex_mem.sv
// ex_mem
//   EX/MEM pipeline register with a single-transaction data-bus sequencer
//   for the 5-stage RV32I core. ALU results pass through with one cycle of
//   latency; loads and stores issue one bus transaction and request a
//   pipeline stall until dbus_ack. Load data is aligned and extended here so
//   mem_wdata already carries the write-back value.
//
//   clk, rst             clock, synchronous active-high reset
//   ex_waddr/we/wdata    EX results (destination, write enable, ALU result)
//   ex_ls_op, ex_funct3  load/store op and RV32I width/sign code
//   ex_maddr, ex_sdata   effective address, store data
//   stall_i, flush_i     hold / bubble from ctrl (flush wins)
//   mem_waddr/we/wdata   to MEM stage
//   dbus                 data bus (ex_mem_if.master)
//   stallreq_o           stall request to ctrl while waiting for ack
//   misalign_o           one-cycle misaligned-access pulse
//
//   Optional build macro EX_MEM_MISALIGN_EXC_EN: misaligned half/word
//   accesses are rejected with misalign_o instead of being masked.
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32   // fixed at 32 for RV32
) (
    input  logic          clk,
    input  logic          rst,
    input  reg_addr_t     ex_waddr,
    input  logic          ex_we,
    input  logic [DW-1:0] ex_wdata,
    input  logic [1:0]    ex_ls_op,
    input  logic [2:0]    ex_funct3,
    input  logic [AW-1:0] ex_maddr,
    input  logic [DW-1:0] ex_sdata,
    input  logic          stall_i,
    input  logic          flush_i,
    output reg_addr_t     mem_waddr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    ex_mem_if.master      dbus,
    output logic          stallreq_o,
    output logic          misalign_o
);

    state_e        state_reg, state_next;

    reg_addr_t     waddr_reg;
    logic          we_lat_reg;     // we as latched, restored after the bus op
    logic          mem_we_reg;     // we as presented to MEM
    logic [DW-1:0] wdata_reg;
    logic [1:0]    ls_op_reg;
    logic [2:0]    funct3_reg;
    logic [AW-1:0] maddr_reg;
    logic [DW-1:0] sdata_reg;
    logic          discard_reg;    // flushed while busy: drop the result

    logic          idle, busy, latch_en, bubble_en;
    logic          ex_is_mem, ex_misaligned, start_xfer, drop;

    logic [3:0]    al_sel;
    logic [31:0]   al_wdata, al_rdata;

    assign idle      = (state_reg == ST_IDLE);
    assign busy      = (state_reg == ST_BUSY);
    assign bubble_en = idle && flush_i;
    assign latch_en  = idle && !flush_i && !stall_i;
    assign ex_is_mem = is_mem_op(ex_ls_op);

`ifdef EX_MEM_MISALIGN_EXC_EN
    logic misalign_reg;
    assign ex_misaligned = ex_is_mem && is_misaligned(ex_funct3, ex_maddr[1:0]);
    assign misalign_o    = misalign_reg;

    always_ff @(posedge clk) begin
        if (rst) misalign_reg <= 1'b0;
        else     misalign_reg <= latch_en && ex_misaligned;
    end
`else
    assign ex_misaligned = 1'b0;
    assign misalign_o    = 1'b0;
`endif

    assign start_xfer = latch_en && ex_is_mem && !ex_misaligned;
    // A flush arriving in the ack cycle itself also discards the result.
    assign drop       = discard_reg || flush_i;

    ex_mem_ls_align u_align (
        .funct3    (funct3_reg),
        .addr_lo   (maddr_reg[1:0]),
        .sdata     (sdata_reg),
        .rdata     (dbus.dbus_rdata),
        .sel       (al_sel),
        .wdata     (al_wdata),
        .rdata_ext (al_rdata)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start_xfer)    state_next = ST_BUSY;
            ST_BUSY: if (dbus.dbus_ack) state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs. Bus fields come straight from registers that are frozen
    // while busy, so they stay stable until ack; they read zero when idle.
    always_comb begin
        dbus.dbus_req   = busy;
        dbus.dbus_wr    = busy && (ls_op_reg == LS_STORE);
        dbus.dbus_addr  = busy ? {maddr_reg[AW-1:2], 2'b00} : '0;
        dbus.dbus_sel   = busy ? al_sel : 4'b0000;
        dbus.dbus_wdata = busy ? al_wdata : 32'h0;
        stallreq_o      = busy && !dbus.dbus_ack;
    end

    // Pipeline register / result datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_reg   <= '0;
            we_lat_reg  <= 1'b0;
            mem_we_reg  <= 1'b0;
            wdata_reg   <= '0;
            ls_op_reg   <= LS_NONE;
            funct3_reg  <= 3'b000;
            maddr_reg   <= '0;
            sdata_reg   <= '0;
            discard_reg <= 1'b0;
        end else if (bubble_en) begin
            waddr_reg   <= '0;
            we_lat_reg  <= 1'b0;
            mem_we_reg  <= 1'b0;
            wdata_reg   <= '0;
            ls_op_reg   <= LS_NONE;
        end else if (latch_en) begin
            waddr_reg   <= ex_waddr;
            we_lat_reg  <= ex_we;
            // Memory ops (and rejected misaligned ones) hide we until done.
            mem_we_reg  <= ex_is_mem ? 1'b0 : ex_we;
            wdata_reg   <= ex_wdata;
            ls_op_reg   <= ex_ls_op;
            funct3_reg  <= ex_funct3;
            maddr_reg   <= ex_maddr;
            sdata_reg   <= ex_sdata;
            discard_reg <= 1'b0;
        end else if (busy) begin
            if (flush_i) discard_reg <= 1'b1;
            if (dbus.dbus_ack) begin
                mem_we_reg  <= drop ? 1'b0 : we_lat_reg;
                if ((ls_op_reg == LS_LOAD) && !drop) wdata_reg <= al_rdata;
                discard_reg <= 1'b0;
            end
        end
    end

    assign mem_waddr = waddr_reg;
    assign mem_we    = mem_we_reg;
    assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem
//   Self-checking bench for ex_mem: directed cases with literal expectations
//   followed by randomized traffic against a transaction-level model. Every
//   cycle, all DUT outputs are compared with the model on the falling edge.
module tb_ex_mem;

    localparam int AW = 32;
`ifdef EX_MEM_MISALIGN_EXC_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_waddr;
    logic        ex_we;
    logic [31:0] ex_wdata;
    logic [1:0]  ex_ls_op;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_maddr;
    logic [31:0] ex_sdata;
    logic        stall_i, flush_i;
    logic [4:0]  mem_waddr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        stallreq_o, misalign_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_mem_if #(.AW(AW)) bus ();

    ex_mem #(.AW(AW), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_waddr   (ex_waddr),
        .ex_we      (ex_we),
        .ex_wdata   (ex_wdata),
        .ex_ls_op   (ex_ls_op),
        .ex_funct3  (ex_funct3),
        .ex_maddr   (ex_maddr),
        .ex_sdata   (ex_sdata),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .mem_waddr  (mem_waddr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .dbus       (bus),
        .stallreq_o (stallreq_o),
        .misalign_o (misalign_o)
    );

    // ---------------- reference model (transaction level) ----------------
    bit          m_busy, m_discard, m_mis;
    logic [4:0]  l_waddr;
    bit          l_we;
    logic [1:0]  l_ls;
    logic [2:0]  l_f3;
    logic [31:0] l_addr, l_sdata;
    logic [4:0]  o_waddr;
    bit          o_we;
    logic [31:0] o_wdata;

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Byte offset rounded down to the natural alignment of the access.
    function automatic int eff_off(input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        return off - (off % nbytes(f3));
    endfunction

    function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << nbytes(f3)) - 1) << eff_off(f3, a));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % nbytes(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v, mask;
        int bits;
        if (nbytes(f3) == 4) return rd;
        bits = 8 * nbytes(f3);
        mask = (32'h1 << bits) - 32'h1;
        v = (rd >> (8 * eff_off(f3, a))) & mask;
        if (!f3[2] && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(f3)) != 0;
    endfunction

    task automatic model_update();
        bit is_mem, mis, drop;
        if (rst) begin
            m_busy = 0; m_discard = 0; m_mis = 0;
            l_waddr = 0; l_we = 0; l_ls = 0; l_f3 = 0; l_addr = 0; l_sdata = 0;
            o_waddr = 0; o_we = 0; o_wdata = 0;
        end else begin
            m_mis = 0;
            if (!m_busy) begin
                if (flush_i) begin
                    o_waddr = 0; o_we = 0; o_wdata = 0; l_ls = 0; l_we = 0;
                end else if (!stall_i) begin
                    is_mem = (ex_ls_op == 2'd1) || (ex_ls_op == 2'd2);
                    mis = MIS_EN && is_mem && m_misaligned(ex_funct3, ex_maddr);
                    l_waddr = ex_waddr; l_we = ex_we; l_ls = ex_ls_op;
                    l_f3 = ex_funct3; l_addr = ex_maddr; l_sdata = ex_sdata;
                    o_waddr = ex_waddr; o_wdata = ex_wdata;
                    o_we = is_mem ? 1'b0 : ex_we;
                    if (is_mem && !mis) begin m_busy = 1; m_discard = 0; end
                    m_mis = mis;
                end
            end else if (bus.dbus_ack) begin
                drop = m_discard || flush_i;
                o_we = drop ? 1'b0 : l_we;
                if (l_ls == 2'd1 && !drop) o_wdata = m_load(l_f3, l_addr, bus.dbus_rdata);
                m_busy = 0; m_discard = 0;
            end else if (flush_i) begin
                m_discard = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("mem_we",     32'(mem_we),     32'(o_we));
        chk("mem_waddr",  32'(mem_waddr),  32'(o_waddr));
        chk("mem_wdata",  mem_wdata,       o_wdata);
        chk("dbus_req",   32'(bus.dbus_req), 32'(m_busy));
        chk("dbus_wr",    32'(bus.dbus_wr),  32'(m_busy && l_ls == 2'd2));
        chk("dbus_addr",  bus.dbus_addr,   m_busy ? {l_addr[31:2], 2'b00} : 32'h0);
        chk("dbus_sel",   32'(bus.dbus_sel), m_busy ? 32'(m_sel(l_f3, l_addr)) : 32'h0);
        chk("dbus_wdata", bus.dbus_wdata,  m_busy ? m_wdata(l_f3, l_sdata) : 32'h0);
        chk("stallreq_o", 32'(stallreq_o), 32'(m_busy && !bus.dbus_ack));
        chk("misalign_o", 32'(misalign_o), 32'(m_mis));
    endtask

    // One clock: compare on the falling edge, advance the model on the
    // rising edge, return shortly after it so the caller can drive inputs.
    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_ex(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [1:0] ls, input logic [2:0] f3,
                          input logic [31:0] ma, input logic [31:0] sd);
        ex_we = we; ex_waddr = wa; ex_wdata = wd; ex_ls_op = ls;
        ex_funct3 = f3; ex_maddr = ma; ex_sdata = sd;
    endtask

    task automatic set_idle();
        set_ex(1'b0, 5'd0, 32'h0, 2'd0, 3'd0, 32'h0, 32'h0);
    endtask

    // ---------------- random bus slave ----------------
    int wait_cnt = -1;

    task automatic slave_drive();
        if (rst) begin
            bus.dbus_ack = 1'b0;
            wait_cnt = -1;
        end else if (bus.dbus_req) begin
            if (wait_cnt < 0) wait_cnt = int'($urandom_range(0, 3));
            if (wait_cnt == 0) begin
                bus.dbus_ack = 1'b1;
                bus.dbus_rdata = $urandom;
                wait_cnt = -1;
            end else begin
                bus.dbus_ack = 1'b0;
                wait_cnt--;
            end
        end else begin
            // Spurious acks while idle must be ignored.
            bus.dbus_ack = ($urandom_range(0, 7) == 0);
            bus.dbus_rdata = $urandom;
            wait_cnt = -1;
        end
    endtask

    logic [2:0] f3_tab [5];

    initial begin
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;

        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        bus.dbus_ack = 1'b0; bus.dbus_rdata = 32'h0;
        set_idle();
        @(posedge clk);
        model_update();
        #1;
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_mem_we",   32'(mem_we), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_dbus_req", 32'(bus.dbus_req), 32'h0);
        chk("rst_stallreq", 32'(stallreq_o), 32'h0);
        chk("rst_misalign", 32'(misalign_o), 32'h0);
        $display("reset: mem_we=%0b req=%0b", mem_we, bus.dbus_req);

        // ALU op passes through with one cycle of latency
        set_ex(1'b1, 5'd5, 32'h1234, 2'd0, 3'd0, 32'h0, 32'h0);
        step();
        set_idle();
        #1;
        chk("alu_mem_we",    32'(mem_we), 32'h1);
        chk("alu_mem_waddr", 32'(mem_waddr), 32'd5);
        chk("alu_mem_wdata", mem_wdata, 32'h1234);
        chk("alu_dbus_req",  32'(bus.dbus_req), 32'h0);
        chk("alu_stallreq",  32'(stallreq_o), 32'h0);
        $display("ALU x5 <= 0x%08h", mem_wdata);

        // LB at 0x103, three wait cycles
        set_ex(1'b1, 5'd3, 32'hDEAD, 2'd1, 3'b000, 32'h103, 32'h0);
        step();
        set_idle();
        stall_i = 1'b1;
        #1;
        chk("lb_dbus_addr", bus.dbus_addr, 32'h100);
        chk("lb_dbus_sel",  32'(bus.dbus_sel), 32'b1000);
        chk("lb_mem_we",    32'(mem_we), 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("lb_stallreq_wait", 32'(stallreq_o), 32'h1);
            step();
            #1;
        end
        bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'h80FF_FF7F;
        #1;
        chk("lb_stallreq_ack", 32'(stallreq_o), 32'h0);
        step();
        bus.dbus_ack = 1'b0; stall_i = 1'b0;
        #1;
        chk("lb_mem_wdata", mem_wdata, 32'hFFFF_FF80);
        chk("lb_mem_we",    32'(mem_we), 32'h1);
        chk("lb_req_done",  32'(bus.dbus_req), 32'h0);
        $display("LB 0x103 -> 0x%08h", mem_wdata);

        // LHU at 0x202, zero-wait ack
        set_ex(1'b1, 5'd4, 32'h0, 2'd1, 3'b101, 32'h202, 32'h0);
        step();
        set_idle();
        bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'hBEEF_0000;
        #1;
        chk("lhu_dbus_sel",  32'(bus.dbus_sel), 32'b1100);
        chk("lhu_stallreq",  32'(stallreq_o), 32'h0);
        step();
        bus.dbus_ack = 1'b0;
        #1;
        chk("lhu_mem_wdata", mem_wdata, 32'h0000_BEEF);
        $display("LHU 0x202 -> 0x%08h", mem_wdata);

        // SB at 0x301
        set_ex(1'b0, 5'd0, 32'h0, 2'd2, 3'b000, 32'h301, 32'h0000_00AB);
        step();
        set_idle();
        #1;
        chk("sb_dbus_wr",    32'(bus.dbus_wr), 32'h1);
        chk("sb_dbus_sel",   32'(bus.dbus_sel), 32'b0010);
        chk("sb_dbus_wdata", bus.dbus_wdata, 32'hABAB_ABAB);
        chk("sb_mem_we",     32'(mem_we), 32'h0);
        bus.dbus_ack = 1'b1;
        step();
        bus.dbus_ack = 1'b0;
        #1;
        chk("sb_mem_we_done", 32'(mem_we), 32'h0);
        $display("SB 0x301 wdata=0xABABABAB");

        // Flush during a busy load: request held, result dropped
        set_ex(1'b1, 5'd7, 32'h0, 2'd1, 3'b010, 32'h500, 32'h0);
        step();
        set_idle();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        chk("flush_req_held", 32'(bus.dbus_req), 32'h1);
        bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'h1234_5678;
        step();
        bus.dbus_ack = 1'b0;
        #1;
        chk("flush_mem_we", 32'(mem_we), 32'h0);
        set_ex(1'b1, 5'd9, 32'h55, 2'd0, 3'd0, 32'h0, 32'h0);
        step();
        #1;
        chk("post_flush_we",    32'(mem_we), 32'h1);
        chk("post_flush_waddr", 32'(mem_waddr), 32'd9);
        $display("LW 0x500 flushed, next ALU x9 <= 0x%08h", mem_wdata);

        // Stall for two cycles holds everything
        set_ex(1'b1, 5'd12, 32'h999, 2'd0, 3'd0, 32'h0, 32'h0);
        stall_i = 1'b1;
        step();
        step();
        #1;
        chk("stall_waddr", 32'(mem_waddr), 32'd9);
        chk("stall_wdata", mem_wdata, 32'h55);
        chk("stall_we",    32'(mem_we), 32'h1);
        // Flush wins over stall
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; stall_i = 1'b0;
        #1;
        chk("flush_prio_we",    32'(mem_we), 32'h0);
        chk("flush_prio_waddr", 32'(mem_waddr), 32'd0);
        $display("stall x2 held, flush+stall -> bubble");

        // LW at 0x402
        set_ex(1'b1, 5'd10, 32'h0, 2'd1, 3'b010, 32'h402, 32'h0);
        step();
        set_idle();
        #1;
`ifdef EX_MEM_MISALIGN_EXC_EN
        chk("lw_mis_req",      32'(bus.dbus_req), 32'h0);
        chk("lw_mis_pulse",    32'(misalign_o), 32'h1);
        chk("lw_mis_mem_we",   32'(mem_we), 32'h0);
        step();
        #1;
        chk("lw_mis_pulse_end", 32'(misalign_o), 32'h0);
        $display("LW 0x402 misaligned");
`else
        chk("lw_mask_addr", bus.dbus_addr, 32'h400);
        chk("lw_mask_sel",  32'(bus.dbus_sel), 32'b1111);
        bus.dbus_ack = 1'b1;
        step();
        bus.dbus_ack = 1'b0;
        $display("LW 0x402 masked to 0x400");
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            flush_i = ($urandom_range(0, 15) == 0);
            stall_i = ($urandom_range(0, 5) == 0);
            set_ex(1'($urandom), 5'($urandom), $urandom, 2'($urandom_range(0, 3)),
                   f3_tab[$urandom_range(0, 4)], $urandom, $urandom);
            slave_drive();
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- EX/MEM pipeline register plus data-bus sequencer for the 5-stage RV32I core.
- Latches EX results every cycle and presents them to the MEM stage.
- For loads and stores, issues one data-bus transaction and holds the pipeline via stallreq_o until dbus_ack.
- Load data is aligned and sign- or zero-extended here, so MEM sees the final write-back value on mem_wdata.

Parameters:
- AW, 32, data-bus address width.
- DW, 32, data width; fixed at 32 for RV32.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- ex_waddr  in  5  destination register
- ex_we  in  1  register write enable
- ex_wdata  in  32  ALU result
- ex_ls_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- ex_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_maddr  in  AW  effective address
- ex_sdata  in  32  store data (rs2)
- stall_i  in  1  hold register (from ctrl)
- flush_i  in  1  insert bubble
- mem_waddr  out  5  to MEM stage
- mem_we  out  1  to MEM stage
- mem_wdata  out  32  to MEM stage
- dbus_req  out  1  bus request
- dbus_wr  out  1  1 = store
- dbus_addr  out  AW  word-aligned address (low 2 bits zero)
- dbus_wdata  out  32  lane-replicated store data
- dbus_sel  out  4  byte enables
- dbus_ack  in  1  transaction complete; rdata valid the same cycle
- dbus_rdata  in  32  read data
- stallreq_o  out  1  to ctrl
- misalign_o  out  1  only with the optional feature

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE.
- FSM states: IDLE and BUSY.
- IDLE, no stall or flush: latch ex_* on each edge (1-cycle latency).
  - If the latched ex_ls_op is load or store, move to BUSY.
  - Entering BUSY forces mem_we = 0.
- BUSY:
  - dbus_req = 1; dbus_addr, dbus_wr, dbus_sel and dbus_wdata are held stable until ack.
  - stallreq_o = ~dbus_ack (combinational, high only in BUSY).
  - On the ack edge, return to IDLE.
  - Load: mem_wdata = extracted rdata; mem_we restored to the latched we.
  - Store: mem_we stays as latched (normally 0).
- Zero-wait ack: ack may arrive in the first BUSY cycle.
  - Minimum load latency is 2 cycles from latch to valid mem_wdata.
- Byte enables (sel):
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: 4'b0011 << addr[1:0] (addr[1:0] must be 0 or 2).
  - W: 4'b1111.
- Store data: byte replicated ×4, half replicated ×2, word unchanged.
- Load extraction: select the byte or half by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU).
- stall_i = 1 in IDLE: hold all registers; no new latch.
  - The ex_* inputs are not sampled.
- flush_i = 1 in IDLE: latch a bubble (we = 0, waddr = 0, wdata = 0, ls_op = none).
  - flush_i has priority over stall_i.
- flush_i in BUSY: the bus transaction is not aborted; dbus_req is held until ack.
  - A "discard" flag is set; on ack, mem_we = 0 and the result is dropped.
  - The FSM then returns to IDLE.
- Stall ownership: the register never accepts new EX data while BUSY.
  - ctrl is required to stall EX whenever stallreq_o is high.
- dbus_ack while IDLE is ignored.
- Reset mid-transaction: immediate return to IDLE with dbus_req = 0; the bus slave is reset by the same rst.

Optional Feature:
- Macro: EX_MEM_MISALIGN_EXC_EN.
- Defined:
  - A halfword with addr[0] = 1, or a word with addr[1:0] ≠ 0, does not enter BUSY and issues no bus request.
  - misalign_o = 1 for one cycle, mem_we = 0.
- Undefined:
  - misalign_o is tied to 0.
  - addr low bits are masked to the natural alignment of the access width before sel and extraction (half: addr[0] = 0; word: addr[1:0] = 0).

Decomposition:
- Shared defines file, alongside the existing RegAddrBus and RegBus defines, holds:
  - LS_NONE, LS_LOAD, LS_STORE.
  - funct3 width codes.
  - FSM state encodings.
- One natural sub-module: ls_align, a combinational block producing sel and wdata replication for stores and rdata extraction for loads. Instantiated once in ex_mem.

Test Plan:
- ALU op: ex_we=1, waddr=5, wdata=0x1234, ls_op=none → next cycle mem_we=1, mem_waddr=5, mem_wdata=0x1234; dbus_req=0; stallreq_o=0.
- LB with addr=0x103, rdata=0x80FF_FF7F, ack after 3 wait cycles → dbus_addr=0x100, sel=4'b1000, stallreq_o high for 3 cycles, mem_wdata=0xFFFF_FF80.
- LHU with addr=0x202, rdata=0xBEEF_0000, zero-wait ack → sel=4'b1100, mem_wdata=0x0000_BEEF, stallreq_o low in the ack cycle.
- SB with addr=0x301, sdata=0xAB → dbus_wr=1, sel=4'b0010, dbus_wdata=0xABAB_ABAB, mem_we=0.
- flush_i during a BUSY load → dbus_req held until ack; then mem_we=0; next ALU op latched normally. Separately, stall_i held 2 cycles in IDLE → outputs unchanged.
- With EX_MEM_MISALIGN_EXC_EN, LW at addr=0x402 → no dbus_req, misalign_o pulse, mem_we=0. Without the macro → dbus_addr=0x400, sel=4'b1111.
